// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list queue manager: FSM state type and
// default pool geometry.
package ll_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ll_state_t;

  localparam int LL_N_DEF = 256;
  localparam int LL_C_DEF = 4;

endpackage

// File: rtl/ll_next_mem.sv
// Next-pointer array shared by the free list and all channel lists.
// Two write ports (channel link, free link / init) and two async read ports.
module ll_next_mem #(
  parameter int N     = 256,
  parameter int W_PTR = $clog2(N)
) (
  input  logic             clk,
  input  logic             ch_we,
  input  logic [W_PTR-1:0] ch_waddr,
  input  logic [W_PTR-1:0] ch_wdata,
  input  logic             fr_we,
  input  logic [W_PTR-1:0] fr_waddr,
  input  logic [W_PTR-1:0] fr_wdata,
  input  logic [W_PTR-1:0] free_raddr,
  output logic [W_PTR-1:0] free_rdata,
  input  logic [W_PTR-1:0] pop_raddr,
  output logic [W_PTR-1:0] pop_rdata
);

  logic [W_PTR-1:0] mem [N];

  // The two write addresses belong to disjoint lists, so they never collide.
  always_ff @(posedge clk) begin
    if (ch_we) mem[ch_waddr] <= ch_wdata;
    if (fr_we) mem[fr_waddr] <= fr_wdata;
  end

  assign free_rdata = mem[free_raddr];
  assign pop_rdata  = mem[pop_raddr];

endmodule

// File: rtl/ll_queue_mgr.sv
// Multi-channel linked-list queue manager: one free list plus C channel lists
// threaded through a single next-pointer array of N nodes.
module ll_queue_mgr
  import ll_pkg::*;
#(
  parameter int N     = LL_N_DEF,
  parameter int C     = LL_C_DEF,
  parameter int W_PTR = $clog2(N),
  parameter int W_CH  = $clog2(C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [W_CH-1:0]  push_ch,
  output logic             push_rdy,
  output logic [W_PTR-1:0] push_ptr,
  input  logic             pop_vld,
  input  logic [W_CH-1:0]  pop_ch,
  output logic             pop_rdy,
  output logic [W_PTR-1:0] out_ptr,
  output logic             out_ptr_vld,
  output logic [W_PTR:0]   free_cnt,
  output logic [C-1:0]     ch_empty,
  output ll_state_t        dbg_state
);

  typedef logic [W_PTR-1:0] ptr_t;
  typedef logic [W_PTR:0]   cnt_t;

  localparam ptr_t LAST_IDX = ptr_t'(N - 1);
  localparam cnt_t N_CNT    = cnt_t'(N);

  // Handshake: a push/pop fires when its vld and rdy are both high at the
  // rising edge; requests seen without rdy are dropped, never queued.

  ll_state_t state_q, state_d;
  ptr_t      init_idx_q, init_idx_d;
  ptr_t      free_head_q, free_head_d;
  ptr_t      free_tail_q, free_tail_d;
  cnt_t      free_cnt_q, free_cnt_d;
  ptr_t      head_q [C];
  ptr_t      head_d [C];
  ptr_t      tail_q [C];
  ptr_t      tail_d [C];
  cnt_t      cnt_q  [C];
  cnt_t      cnt_d  [C];
  ptr_t      out_ptr_q, out_ptr_d;
  logic      out_vld_q, out_vld_d;

  logic      ch_we, fr_we;
  ptr_t      ch_waddr, ch_wdata, fr_waddr, fr_wdata;
  ptr_t      free_nxt, pop_nxt, pop_node;
  logic      push_fire, pop_fire;

  ll_next_mem #(.N(N), .W_PTR(W_PTR)) u_next (
    .clk        (clk),
    .ch_we      (ch_we),
    .ch_waddr   (ch_waddr),
    .ch_wdata   (ch_wdata),
    .fr_we      (fr_we),
    .fr_waddr   (fr_waddr),
    .fr_wdata   (fr_wdata),
    .free_raddr (free_head_q),
    .free_rdata (free_nxt),
    .pop_raddr  (pop_node),
    .pop_rdata  (pop_nxt)
  );

  assign pop_node  = head_q[pop_ch];
  assign push_rdy  = (state_q == RUN) && (free_cnt_q != '0);
  assign pop_rdy   = (state_q == RUN) && (cnt_q[pop_ch] != '0);
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;
  assign push_ptr  = free_head_q;
  assign out_ptr     = out_ptr_q;
  assign out_ptr_vld = out_vld_q;
  assign free_cnt    = free_cnt_q;
  assign dbg_state   = state_q;

  always_comb begin
    ch_empty = '1;
    for (int c = 0; c < C; c++) ch_empty[c] = (cnt_q[c] == '0);
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    free_head_d = free_head_q;
    free_tail_d = free_tail_q;
    free_cnt_d  = free_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    out_ptr_d   = out_ptr_q;
    out_vld_d   = 1'b0;
    ch_we       = 1'b0;
    ch_waddr    = tail_q[push_ch];
    ch_wdata    = free_head_q;
    fr_we       = 1'b0;
    fr_waddr    = free_tail_q;
    fr_wdata    = pop_node;

    if (state_q == INIT) begin
      // Thread every node into one chain 0 -> 1 -> ... -> N-1.
      fr_we      = 1'b1;
      fr_waddr   = init_idx_q;
      fr_wdata   = init_idx_q + ptr_t'(1);
      init_idx_d = init_idx_q + ptr_t'(1);
      if (init_idx_q == LAST_IDX) begin
        state_d     = RUN;
        free_head_d = '0;
        free_tail_d = LAST_IDX;
        free_cnt_d  = N_CNT;
      end
    end else begin
      if (push_fire) begin
        ch_we = (cnt_q[push_ch] != '0);
        if (cnt_q[push_ch] == '0) head_d[push_ch] = free_head_q;
        tail_d[push_ch] = free_head_q;
        cnt_d[push_ch]  = cnt_d[push_ch] + cnt_t'(1);
        free_head_d     = free_nxt;
      end
      if (pop_fire) begin
        out_ptr_d = pop_node;
        out_vld_d = 1'b1;
        // A single-entry channel refilled in the same cycle takes the new node.
        if (push_fire && (push_ch == pop_ch) && (cnt_q[pop_ch] == cnt_t'(1)))
          head_d[pop_ch] = free_head_q;
        else
          head_d[pop_ch] = pop_nxt;
        cnt_d[pop_ch] = cnt_d[pop_ch] - cnt_t'(1);
        fr_we         = (free_cnt_q != '0);
        // Empty free list, or its last node leaving now: popped node is the head.
        if ((free_cnt_q == '0) || (push_fire && (free_cnt_q == cnt_t'(1))))
          free_head_d = pop_node;
        free_tail_d = pop_node;
      end
      free_cnt_d = free_cnt_q - cnt_t'(push_fire) + cnt_t'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      free_head_q <= '0;
      free_tail_q <= '0;
      free_cnt_q  <= '0;
      out_ptr_q   <= '0;
      out_vld_q   <= 1'b0;
      for (int c = 0; c < C; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      free_head_q <= free_head_d;
      free_tail_q <= free_tail_d;
      free_cnt_q  <= free_cnt_d;
      out_ptr_q   <= out_ptr_d;
      out_vld_q   <= out_vld_d;
      for (int c = 0; c < C; c++) begin
        head_q[c] <= head_d[c];
        tail_q[c] <= tail_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

endmodule

// File: tb/tb_ll_queue_mgr.sv
// Bench for ll_queue_mgr: vector table for FIFO/interleave behaviour, directed
// corner sequences, and random traffic scored against a list-level model.
module tb_ll_queue_mgr;
  import ll_pkg::*;

  localparam int N = 256;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_vld = 1'b0;
  logic [1:0] push_ch = '0;
  logic       push_rdy;
  logic [7:0] push_ptr;
  logic       pop_vld = 1'b0;
  logic [1:0] pop_ch = '0;
  logic       pop_rdy;
  logic [7:0] out_ptr;
  logic       out_ptr_vld;
  logic [8:0] free_cnt;
  logic [3:0] ch_empty;
  ll_state_t  dbg_state;

  ll_queue_mgr #(.N(N), .C(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_vld    (push_vld),
    .push_ch     (push_ch),
    .push_rdy    (push_rdy),
    .push_ptr    (push_ptr),
    .pop_vld     (pop_vld),
    .pop_ch      (pop_ch),
    .pop_rdy     (pop_rdy),
    .out_ptr     (out_ptr),
    .out_ptr_vld (out_ptr_vld),
    .free_cnt    (free_cnt),
    .ch_empty    (ch_empty),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: free list as a queue, channels as ring buffers
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq_mem [C][N];
  int         mq_rd [C];
  int         mq_n  [C];

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) fq.push_back(8'(i));
    for (int c = 0; c < C; c++) begin
      mq_rd[c] = 0;
      mq_n[c]  = 0;
    end
  endtask

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int c = 0; c < C; c++) e[c] = (mq_n[c] == 0);
    return e;
  endfunction

  // Driver tasks
  task automatic do_reset(input int hold);
    rst = 1'b1;
    repeat (hold) @(negedge clk);
    push_vld = 1'b0;
    pop_vld  = 1'b0;
    #1;
    chk("rst_push_rdy", push_rdy, 0);
    chk("rst_pop_rdy", pop_rdy, 0);
    chk("rst_push_ptr", push_ptr, 0);
    chk("rst_out_ptr", out_ptr, 0);
    chk("rst_out_vld", out_ptr_vld, 0);
    chk("rst_free_cnt", free_cnt, 0);
    chk("rst_ch_empty", ch_empty, 4'b1111);
    chk("rst_state", dbg_state, INIT);
    rst = 1'b0;
  endtask

  task automatic wait_run();
    int   cyc;
    logic saw_vld;
    cyc = 0;
    saw_vld = 1'b0;
    while (!push_rdy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (out_ptr_vld) saw_vld = 1'b1;
    end
    chk("init_cycles", cyc, N);
    chk("init_free_cnt", free_cnt, N);
    chk("init_ch_empty", ch_empty, 4'b1111);
    chk("init_no_vld", saw_vld, 0);
    chk("init_state", dbg_state, RUN);
    model_reset();
  endtask

  // One model-checked cycle: combinational outputs before the edge,
  // registered outputs after it.
  task automatic step(input logic pv, input int pc, input logic qv, input int qc);
    logic       e_push_rdy, e_pop_rdy, pop_ok;
    logic [7:0] node;
    push_vld = pv;
    push_ch  = 2'(pc);
    pop_vld  = qv;
    pop_ch   = 2'(qc);
    #1;
    e_push_rdy = (fq.size() != 0);
    e_pop_rdy  = (mq_n[qc] != 0);
    chk("push_rdy", push_rdy, e_push_rdy);
    if (e_push_rdy) chk("push_ptr", push_ptr, fq[0]);
    chk("pop_rdy", pop_rdy, e_pop_rdy);
    pop_ok = qv && e_pop_rdy;
    if (pop_ok) begin
      node = mq_mem[qc][mq_rd[qc]];
      mq_rd[qc] = (mq_rd[qc] + 1) % N;
      mq_n[qc]--;
      fq.push_back(node);
      exp_q.push_back(node);
    end
    if (pv && e_push_rdy) begin
      node = fq.pop_front();
      mq_mem[pc][(mq_rd[pc] + mq_n[pc]) % N] = node;
      mq_n[pc]++;
    end
    @(negedge clk);
    push_vld = 1'b0;
    pop_vld  = 1'b0;
    chk("out_vld", out_ptr_vld, pop_ok);
    if (pop_ok) chk("out_ptr", out_ptr, exp_q.pop_front());
    chk("free_cnt", free_cnt, fq.size());
    chk("ch_empty", ch_empty, model_empty());
  endtask

  // Vector table
  typedef struct {
    logic       reinit;
    logic       pv;
    logic [1:0] pc;
    logic       qv;
    logic [1:0] qc;
    logic       e_push_rdy;
    logic [7:0] e_push_ptr;
    logic       e_pop_rdy;
    logic       e_vld;
    logic [7:0] e_out;
    logic [8:0] e_free;
    logic [3:0] e_empty;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0] popped;
    int         pct;

    // FIFO order on ch1
    vecs[0]  = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 9'd255, 4'b1101};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd0, 9'd254, 4'b1101};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 8'd2, 1'b1, 1'b0, 8'd0, 9'd253, 4'b1101};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 8'd3, 1'b1, 1'b1, 8'd0, 9'd254, 4'b1101};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 8'd3, 1'b1, 1'b1, 8'd1, 9'd255, 4'b1101};
    vecs[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 8'd3, 1'b1, 1'b1, 8'd2, 9'd256, 4'b1111};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 9'd256, 4'b1111};
    // Interleave ch0/ch2, then a pop on empty ch3
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 9'd255, 4'b1110};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 9'd254, 4'b1010};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 8'd2, 1'b1, 1'b0, 8'd0, 9'd253, 4'b1010};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 8'd3, 1'b1, 1'b1, 8'd0, 9'd254, 4'b1010};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 8'd3, 1'b1, 1'b1, 8'd2, 9'd255, 4'b1011};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 8'd3, 1'b1, 1'b1, 8'd1, 9'd256, 4'b1111};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 9'd256, 4'b1111};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].reinit) begin
        do_reset(2);
        wait_run();
      end
      push_vld = vecs[i].pv;
      push_ch  = vecs[i].pc;
      pop_vld  = vecs[i].qv;
      pop_ch   = vecs[i].qc;
      #1;
      chk($sformatf("v%0d_push_rdy", i), push_rdy, vecs[i].e_push_rdy);
      if (vecs[i].e_push_rdy) chk($sformatf("v%0d_push_ptr", i), push_ptr, vecs[i].e_push_ptr);
      chk($sformatf("v%0d_pop_rdy", i), pop_rdy, vecs[i].e_pop_rdy);
      @(negedge clk);
      push_vld = 1'b0;
      pop_vld  = 1'b0;
      chk($sformatf("v%0d_out_vld", i), out_ptr_vld, vecs[i].e_vld);
      if (vecs[i].e_vld) chk($sformatf("v%0d_out_ptr", i), out_ptr, vecs[i].e_out);
      chk($sformatf("v%0d_free_cnt", i), free_cnt, vecs[i].e_free);
      chk($sformatf("v%0d_ch_empty", i), ch_empty, vecs[i].e_empty);
    end

    // Exhaust the pool on ch0
    do_reset(2);
    wait_run();
    repeat (N) step(1'b1, 0, 1'b0, 0);
    chk("exh_free_zero", free_cnt, 0);
    chk("exh_push_rdy_low", push_rdy, 0);
    step(1'b1, 0, 1'b0, 0);
    chk("exh_extra_ignored", free_cnt, 0);
    step(1'b0, 0, 1'b1, 0);
    chk("exh_out_ptr", out_ptr, 0);
    chk("exh_push_rdy_back", push_rdy, 1);
    chk("exh_push_ptr", push_ptr, 0);

    // Same-cycle push+pop on a single-entry channel
    do_reset(2);
    wait_run();
    step(1'b1, 2, 1'b0, 0);
    step(1'b1, 2, 1'b1, 2);
    chk("sim_out_ptr", out_ptr, 0);
    chk("sim_ch2_nonempty", ch_empty[2], 0);
    step(1'b0, 0, 1'b1, 2);
    chk("sim_next_out", out_ptr, 1);

    // Same-cycle push+pop with a single free node, different channels
    repeat (N - 1) step(1'b1, 0, 1'b0, 0);
    chk("f1_free_one", free_cnt, 1);
    popped = mq_mem[0][mq_rd[0]];
    step(1'b1, 1, 1'b1, 0);
    chk("f1_free_stays", free_cnt, 1);
    chk("f1_push_ptr", push_ptr, popped);
    chk("f1_push_ptr_const", push_ptr, 2);

    // Reset mid-RUN with a pop in flight
    do_reset(2);
    wait_run();
    repeat (10) step(1'b1, 0, 1'b0, 0);
    pop_vld = 1'b1;
    pop_ch  = 2'd0;
    do_reset(1);
    wait_run();
    chk("mid_push_ptr", push_ptr, 0);
    pop_vld = 1'b1;
    pop_ch  = 2'd0;
    #1;
    chk("mid_pop_rdy", pop_rdy, 0);
    pop_vld = 1'b0;

    // Random traffic against the model, with phases of varying push pressure
    for (int i = 0; i < 4000; i++) begin
      case ((i / 400) % 5)
        0:       pct = 60;
        1:       pct = 97;
        2:       pct = 50;
        3:       pct = 10;
        default: pct = 80;
      endcase
      step(($urandom_range(0, 99) < pct), $urandom_range(0, C - 1),
           ($urandom_range(0, 99) < (100 - pct / 2)), $urandom_range(0, C - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ll_queue_mgr.md
# ll_queue_mgr

Multi-channel linked-list queue manager over a shared pool of `N` node pointers. It keeps one free list and `C` independent per-channel lists in a single next-pointer array. Push allocates a node from the free list and appends it to a channel tail. Pop removes a channel head, emits it on `out_ptr`/`out_ptr_vld`, and returns it to the free-list tail. It is the parametrised successor of the single-list pointer request generator and feeds pointer streams to downstream buffer logic.

## Interface
- `N`, 256: number of nodes; power of two, ≥ 4.
- `C`, 4: number of channels; ≥ 2.
- `W_PTR`, `$clog2(N)`: pointer width.
- `W_CH`, `$clog2(C)`: channel-index width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `push_vld`  in  1  push request.
- `push_ch`  in  `W_CH`  target channel for push.
- `push_rdy`  out  1  free list non-empty and state RUN.
- `push_ptr`  out  `W_PTR`  node allocated if push fires this cycle; equals free head.
- `pop_vld`  in  1  pop request.
- `pop_ch`  in  `W_CH`  source channel for pop.
- `pop_rdy`  out  1  channel `pop_ch` non-empty and state RUN; combinational on `pop_ch`.
- `out_ptr`  out  `W_PTR`  popped node pointer, registered.
- `out_ptr_vld`  out  1  `out_ptr` valid, single-cycle pulse per pop.
- `free_cnt`  out  `W_PTR+1`  free nodes, 0..N.
- `ch_empty`  out  `C`  per-channel empty flags.

## Operation
- FSM states: INIT, RUN.
  - `rst` forces INIT with `init_idx`=0.
  - INIT writes `next[init_idx]`=`init_idx+1`, one entry per cycle, for N cycles.
  - On `init_idx`==N-1: free head=0, free tail=N-1, `free_cnt`=N, then go to RUN.
- A push fires on `push_vld && push_rdy`:
  - allocated node = free head;
  - if channel non-empty, `next[tail[ch]]`=node; else `head[ch]`=node;
  - `tail[ch]`=node, `cnt[ch]`+1;
  - free head = `next[free head]`, `free_cnt`-1.
- A pop fires on `pop_vld && pop_rdy`:
  - node = `head[ch]`; `head[ch]`=`next[node]`, `cnt[ch]`-1;
  - if free list non-empty, `next[free tail]`=node; else free head=node;
  - free tail = node, `free_cnt`+1.
- Same-cycle push and pop are both allowed, to any channels. Required bypasses:
  - same channel, `cnt`==1: new `head[ch]` = allocated node, not the stale `next[head]`; `cnt` unchanged.
  - `free_cnt`==1: new free head = popped node; `free_cnt` unchanged.
  - `free_cnt`==0: no push; `push_rdy` uses current count, with no bypass from the same-cycle pop.
- Requests while not ready are ignored with no state change. Pop on an empty channel: `pop_rdy`=0, no `out_ptr_vld`.
- Pointer arithmetic wraps modulo N only in INIT. `next[N-1]` is don't-care.
- Per-channel counts are `W_PTR+1` bits; the sum of all channel counts plus `free_cnt` always equals N in RUN.

## Timing
- Reset values: `push_rdy`=0, `pop_rdy`=0, `push_ptr`=0, `out_ptr`=0, `out_ptr_vld`=0, `free_cnt`=0, `ch_empty`=all 1s.
- After `rst` deasserts, the first RUN cycle (`push_rdy`=1) is exactly N cycles later.
- `push_ptr` is combinational from the free-head register, valid whenever `push_rdy`=1.
- Pop latency: `out_ptr`/`out_ptr_vld` appear on the cycle after the pop handshake. Back-to-back pops give back-to-back valids.
- `free_cnt` and `ch_empty` update one cycle after the handshake.
- A push to an empty channel makes `pop_rdy` for that channel 1 on the next cycle. There is no push-to-pop forwarding within the same cycle.
- `rst` asserted mid-RUN:
  - all lists are discarded;
  - outputs take reset values the next cycle;
  - any in-flight `out_ptr_vld` is cancelled;
  - INIT reruns.

## Structure
- Package `ll_pkg`:
  - state enum `ll_state_t` {INIT, RUN};
  - defaults `LL_N_DEF`=256, `LL_C_DEF`=4.
- Width-dependent types are derived inside the module from parameters.
- Sub-module `ll_next_mem`:
  - N×`W_PTR` register array;
  - two synchronous write ports (channel link, free link; addresses never collide in RUN);
  - one INIT write shares the free-link port;
  - two asynchronous read ports (free head, `head[pop_ch]`).
- Top holds the FSM, head/tail/count arrays, free-list registers and the output register.

## Test plan
- Init: hold `rst` 2 cycles, release. Required: `push_rdy` rises exactly 256 cycles later, `free_cnt`=256, `ch_empty`=4'b1111, no `out_ptr_vld`.
- FIFO order, after init: push ch1 ×3 gives `push_ptr` 0,1,2. Pop ch1 ×3 back-to-back gives `out_ptr` 0,1,2 on consecutive cycles; `free_cnt` returns to 256 and the next `push_ptr`=3.
- Interleave, after init: push ch0, ch2, ch0 gives 0,1,2. Pops ch0, ch0, ch2 give `out_ptr` 0, 2, 1. A pop on ch3 with `pop_vld`=1 gives `pop_rdy`=0 and no valid.
- Exhaust, after init: 256 pushes to ch0 give `free_cnt`=0 and `push_rdy`=0; an extra push is ignored. Pop ch0 gives `out_ptr`=0; next cycle `push_rdy`=1, `push_ptr`=0.
- Simultaneous, after init: push ch2 (ptr 0), then same cycle push ch2 + pop ch2. Required: `out_ptr`=0, `head[ch2]`=1, `ch_empty[2]`=0; a later pop gives `out_ptr`=1. Repeat with `free_cnt`=1 and push+pop on different channels. Required: `free_cnt` stays 1 and the next `push_ptr` equals the popped node.
- Reset mid-RUN: with 10 nodes queued on ch0 and a pop in flight, assert `rst` for 1 cycle. Required: next cycle `out_ptr_vld`=0 and all outputs at reset values; INIT lasts 256 cycles; the first `push_ptr`=0; a pop on ch0 gives `pop_rdy`=0.
